// File: rtl/data_mem_if.sv
// data_mem_if: load/store port bundle between the datapath stage and data_mem.
// Ports: MemRead/MemWrite enables, word address, write_data, registered read_data.
// master = datapath side (drives requests), slave = memory side (returns read_data).
interface data_mem_if #(
  parameter int W = 32,
  parameter int N = 5
);
  logic         MemRead;
  logic         MemWrite;
  logic [N-1:0] address;
  logic [W-1:0] write_data;
  logic [W-1:0] read_data;

  modport master (
    output MemRead,
    output MemWrite,
    output address,
    output write_data,
    input  read_data
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  address,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/data_mem.sv
// data_mem: single-port 2^N x W data memory for the load/store stage.
// Latency: writes commit at the edge; reads return one cycle later, held until the next read.
// Backpressure: none, one access of each kind accepted every cycle.
// Ports: clk, rst (sync, active-high, clears array and read register), bus (data_mem_if slave).
module data_mem #(
  parameter int W = 32,
  parameter int N = 5
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);
  localparam int DEPTH = 1 << N;

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_read_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset wins over any concurrent request: the whole array and the
      // read register go to zero, and a pending write is dropped.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_read_data <= '0;
    end else begin
      if (bus.MemWrite) begin
        r_mem[bus.address] <= bus.write_data;
      end
      // Nonblocking semantics make this sample the pre-edge word, so a read
      // and write to the same address in one cycle returns the old data.
      if (bus.MemRead) begin
        r_read_data <= r_mem[bus.address];
      end
    end
  end

  assign bus.read_data = r_read_data;
endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  data_mem_if #(.W(32), .N(5)) bus ();

  data_mem #(.W(32), .N(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: a plain array plus the last read result.
  logic [31:0] m_mem [32];
  logic [31:0] m_rd;
  bit          m_known;

  initial m_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 32'h0;
      m_rd    = 32'h0;
      m_known = 1'b1;
    end else begin
      if (bus.MemRead)  m_rd = m_mem[bus.address];
      if (bus.MemWrite) m_mem[bus.address] = bus.write_data;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      n_cmp++;
      if (bus.read_data !== m_rd) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t: read_data=%h required=%h", $time, bus.read_data, m_rd);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: read_data=%h required=%h", name, act, exp);
    end
  endtask

  // Present one cycle of inputs, let the edge happen, return just after it.
  task automatic step(input logic r, input logic rd, input logic wr,
                      input logic [4:0] a, input logic [31:0] d);
    rst            = r;
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.address    = a;
    bus.write_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [4:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd_word(input logic [4:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.address = '0;
    bus.write_data = '0;
    #1;

    // Initial reset.
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("reset_state", bus.read_data, 32'h0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

    // Reset clears previously written data.
    wr_word(5'd3, 32'hDEADBEEF);
    rd_word(5'd3);
    chk("pre_reset_read3", bus.read_data, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
      chk("during_reset", bus.read_data, 32'h0);
    end
    rd_word(5'd3);
    chk("post_reset_read3", bus.read_data, 32'h0);

    // Fill every address, then read back-to-back.
    for (int i = 0; i < 32; i++) wr_word(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      rd_word(5'(i));
      chk("fill_readback", bus.read_data, 32'(i) * 32'h01010101);
    end

    // Read hold with MemRead low and a changing address.
    wr_word(5'd5, 32'h12345678);
    wr_word(5'd6, 32'h66666666);
    rd_word(5'd5);
    chk("hold_read5", bus.read_data, 32'h12345678);
    step(1'b0, 1'b0, 1'b0, 5'd6, 32'h0);
    chk("hold_addr6_a", bus.read_data, 32'h12345678);
    step(1'b0, 1'b0, 1'b0, 5'd6, 32'h0);
    chk("hold_addr6_b", bus.read_data, 32'h12345678);

    // Read-during-write to the same address returns the old word.
    wr_word(5'd7, 32'h11111111);
    step(1'b0, 1'b1, 1'b1, 5'd7, 32'h22222222);
    chk("rdw_old", bus.read_data, 32'h11111111);
    rd_word(5'd7);
    chk("rdw_new", bus.read_data, 32'h22222222);

    // Write-disabled protection, with and without a read in the cycle.
    wr_word(5'd9, 32'h00000009);
    step(1'b0, 1'b0, 1'b0, 5'd9, 32'hFFFFFFFF);
    step(1'b0, 1'b1, 1'b0, 5'd9, 32'hFFFFFFFF);
    chk("nowrite_read9", bus.read_data, 32'h00000009);
    rd_word(5'd9);
    chk("nowrite_reread9", bus.read_data, 32'h00000009);

    // Unknown address/data with both enables low must not disturb state.
    step(1'b0, 1'b0, 1'b0, 5'bxxxxx, 32'hxxxxxxxx);
    step(1'b0, 1'b0, 1'b0, 5'bxxxxx, 32'hxxxxxxxx);
    chk("x_idle_hold", bus.read_data, 32'h00000009);
    rd_word(5'd4);
    chk("x_idle_read4", bus.read_data, 32'h04040404);

    // Reset beats a concurrent write.
    wr_word(5'd2, 32'h00001234);
    step(1'b1, 1'b1, 1'b1, 5'd2, 32'hAAAA5555);
    chk("rst_vs_wr_rd", bus.read_data, 32'h0);
    rd_word(5'd2);
    chk("rst_vs_wr_addr2", bus.read_data, 32'h0);
    rd_word(5'd31);
    chk("rst_cleared31", bus.read_data, 32'h0);

    idle();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
